// File: rtl/pipe_mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: op/length codes,
// FSM state encoding and the alignment check.
package ma_pkg;

  typedef enum logic [1:0] {
    MA_OP_NONE = 2'b00,
    MA_OP_ST   = 2'b01,
    MA_OP_LDS  = 2'b10,
    MA_OP_LDU  = 2'b11
  } ma_op_e;

  typedef enum logic [1:0] {
    MA_LEN_B = 2'd0,
    MA_LEN_H = 2'd1,
    MA_LEN_W = 2'd2,
    MA_LEN_D = 2'd3
  } ma_len_e;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_WAIT = 2'd2
  } ma_state_e;

  localparam int unsigned FWD_IDX_W = 5;

  // Dword accesses are only legal on a 64-bit data path.
  function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                         input logic [1:0] len,
                                         input int unsigned data_l);
    logic bad;
    case (len)
      MA_LEN_B: bad = 1'b0;
      MA_LEN_H: bad = addr_lo[0];
      MA_LEN_W: bad = |addr_lo[1:0];
      default:  bad = (data_l < 64) || (|addr_lo);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/pipe_mem_stage_if.sv
// Data-cache port of the MA stage: request channel plus load-response pulse.
interface pipe_mem_stage_if #(
  parameter int MADDR_L = 32,
  parameter int DATA_L  = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [MADDR_L-1:0]    mem_req_addr;
  logic [DATA_L/8-1:0]   mem_req_be;
  logic [DATA_L-1:0]     mem_req_wdata;
  logic                  mem_resp_valid;
  logic [DATA_L-1:0]     mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/pipe_mem_stage_align.sv
// Combinational lane alignment: store shift and byte enables, load lane
// extraction with sign/zero extension.
module mem_align
  import ma_pkg::*;
#(
  parameter  int DATA_L = 32,
  localparam int BE_W   = DATA_L / 8,
  localparam int LANE_W = $clog2(BE_W)
) (
  input  logic [1:0]        len,
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_L-1:0] wdata,
  input  logic [DATA_L-1:0] rdata,
  input  logic              sign_ext,
  output logic [BE_W-1:0]   be,
  output logic [DATA_L-1:0] wdata_lane,
  output logic [DATA_L-1:0] rdata_ext
);

  int unsigned       nbytes;
  int unsigned       nbits;
  logic [BE_W-1:0]   be_mask;
  logic [DATA_L-1:0] shifted;
  logic              fill;

  always_comb begin
    nbytes = 32'd1 << len;
    nbits  = nbytes * 8;
    if (nbits > DATA_L) nbits = DATA_L;

    be_mask = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (i < nbytes) be_mask[i] = 1'b1;
    end
    be         = be_mask << lane;
    wdata_lane = wdata << {lane, 3'b000};

    shifted = rdata >> {lane, 3'b000};
    case (len)
      MA_LEN_B: fill = sign_ext & shifted[7];
      MA_LEN_H: fill = sign_ext & shifted[15];
      MA_LEN_W: fill = sign_ext & shifted[31];
      default:  fill = sign_ext & shifted[DATA_L-1];
    endcase

    rdata_ext = '0;
    for (int unsigned i = 0; i < DATA_L; i++) begin
      rdata_ext[i] = (i < nbits) ? shifted[i] : fill;
    end
  end

endmodule

// File: rtl/pipe_mem_stage.sv
// Memory-access pipeline stage between EX and WB: issues aligned cache
// requests, formats load data and drives the WB register and forwarding.
module pipe_mem_stage
  import ma_pkg::*;
#(
  parameter int MADDR_L = 32,
  parameter int DATA_L  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [1:0]           in_len,
  input  logic [MADDR_L-1:0]   in_addr,
  input  logic [DATA_L-1:0]    in_wdata,
  input  logic                 in_wb_e,
  input  logic [4:0]           in_wb_idx,
  pipe_mem_stage_if.master     mem,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_wb_e,
  output logic [4:0]           out_wb_idx,
  output logic [DATA_L-1:0]    out_wb_data,
  output logic                 out_exc,
  output logic [FWD_IDX_W-1:0] fwd_idx,
  output logic [DATA_L-1:0]    fwd_val,
  output logic [FWD_IDX_W-1:0] ld_busy_idx
);

  localparam int BE_W   = DATA_L / 8;
  localparam int LANE_W = $clog2(BE_W);

  ma_state_e           state_q, state_d;
  ma_op_e              op_q;
  logic [1:0]          len_q;
  logic [MADDR_L-1:0]  addr_q;
  logic [DATA_L-1:0]   wdata_q;
  logic                wb_e_q;
  logic [4:0]          wb_idx_q;

  logic                out_valid_q, out_wb_e_q, out_exc_q;
  logic [4:0]          out_wb_idx_q;
  logic [DATA_L-1:0]   out_wb_data_q;

  logic                accept, misal, out_load, is_load, req_active;
  logic                nxt_wb_e, nxt_exc;
  logic [4:0]          nxt_idx;
  logic [DATA_L-1:0]   nxt_data;
  logic [BE_W-1:0]     be_w;
  logic [DATA_L-1:0]   wdata_lane, ld_data;

  assign in_ready   = (state_q == MA_IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign misal      = is_misaligned(in_addr[2:0], in_len, DATA_L);
  assign is_load    = (op_q == MA_OP_LDS) || (op_q == MA_OP_LDU);
  assign req_active = (state_q == MA_REQ);

  mem_align #(.DATA_L(DATA_L)) u_align (
    .len        (len_q),
    .lane       (addr_q[LANE_W-1:0]),
    .wdata      (wdata_q),
    .rdata      (mem.mem_resp_rdata),
    .sign_ext   (op_q == MA_OP_LDS),
    .be         (be_w),
    .wdata_lane (wdata_lane),
    .rdata_ext  (ld_data)
  );

  // Request fields are forced to zero outside REQ so idle outputs stay quiet.
  assign mem.mem_req_valid = req_active;
  assign mem.mem_req_we    = req_active && (op_q == MA_OP_ST);
  assign mem.mem_req_addr  = req_active ? {addr_q[MADDR_L-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign mem.mem_req_be    = req_active ? be_w : '0;
  assign mem.mem_req_wdata = req_active ? wdata_lane : '0;

  always_comb begin
    state_d  = state_q;
    out_load = 1'b0;
    nxt_wb_e = wb_e_q;
    nxt_exc  = 1'b0;
    nxt_idx  = wb_idx_q;
    nxt_data = DATA_L'(addr_q);
    case (state_q)
      MA_IDLE: begin
        if (accept) begin
          nxt_idx  = in_wb_idx;
          nxt_data = DATA_L'(in_addr);
          if (misal) begin
            out_load = 1'b1;
            nxt_exc  = 1'b1;
            nxt_wb_e = 1'b0;
          end else if (ma_op_e'(in_op) == MA_OP_NONE) begin
            out_load = 1'b1;
            nxt_wb_e = in_wb_e;
          end else begin
            state_d = MA_REQ;
          end
        end
      end
      MA_REQ: begin
        if (mem.mem_req_ready) begin
          if (op_q == MA_OP_ST) begin
            out_load = 1'b1;
            state_d  = MA_IDLE;
          end else begin
            state_d = MA_WAIT;
          end
        end
      end
      MA_WAIT: begin
        if (mem.mem_resp_valid) begin
          out_load = 1'b1;
          nxt_data = ld_data;
          state_d  = MA_IDLE;
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= MA_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= MA_OP_NONE;
      len_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wb_e_q   <= 1'b0;
      wb_idx_q <= '0;
    end else if (accept) begin
      op_q     <= ma_op_e'(in_op);
      len_q    <= in_len;
      addr_q   <= in_addr;
      wdata_q  <= in_wdata;
      wb_e_q   <= in_wb_e;
      wb_idx_q <= in_wb_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_wb_e_q    <= 1'b0;
      out_exc_q     <= 1'b0;
      out_wb_idx_q  <= '0;
      out_wb_data_q <= '0;
    end else if (out_load) begin
      out_valid_q   <= 1'b1;
      out_wb_e_q    <= nxt_wb_e;
      out_exc_q     <= nxt_exc;
      out_wb_idx_q  <= nxt_idx;
      out_wb_data_q <= nxt_data;
    end else if (out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_wb_e    = out_wb_e_q;
  assign out_exc     = out_exc_q;
  assign out_wb_idx  = out_wb_idx_q;
  assign out_wb_data = out_wb_data_q;
  assign fwd_idx     = (out_valid_q && out_wb_e_q) ? out_wb_idx_q : '0;
  assign fwd_val     = out_wb_data_q;
  assign ld_busy_idx = ((state_q != MA_IDLE) && is_load && wb_e_q) ? wb_idx_q : '0;

endmodule

// File: doc/pipe_mem_stage.md
# pipe_mem_stage

Parametrised memory-access (MA) pipeline stage between EX and WB. Accepts one EX result per valid/ready handshake and issues aligned load/store requests to the data-cache port. Lane-aligns and sign/zero-extends load data, generates byte enables for stores, and flags misaligned accesses. Drives the WB register and the MA forwarding/hazard outputs, fully synchronous to one clock.

## Interface
- `MADDR_L`, 32, byte-address width
- `DATA_L`, 32, data/word width; 32 or 64
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  EX result valid
- `in_ready`  out  1  stage can accept
- `in_op`  in  2  00 none, 01 store, 10 load signed, 11 load unsigned
- `in_len`  in  2  log2 access bytes: 0 byte, 1 half, 2 word, 3 dword (legal only when DATA_L=64)
- `in_addr`  in  MADDR_L  EX result / byte address
- `in_wdata`  in  DATA_L  store data, LSB-aligned
- `in_wb_e`, `in_wb_idx`  in  1, 5  writeback enable / register index
- `mem_req_valid`  out  1  request valid
- `mem_req_ready`  in  1  cache accepts request
- `mem_req_we`  out  1  1 store, 0 load
- `mem_req_addr`  out  MADDR_L  word-aligned address (low log2(DATA_L/8) bits zero)
- `mem_req_be`  out  DATA_L/8  byte enables
- `mem_req_wdata`  out  DATA_L  lane-shifted store data
- `mem_resp_valid`  in  1  load data valid, one pulse per load
- `mem_resp_rdata`  in  DATA_L  full aligned word
- `out_valid`  out  1  WB entry valid
- `out_ready`  in  1  WB consumes entry
- `out_wb_e`, `out_wb_idx`, `out_wb_data`  out  1, 5, DATA_L  WB payload
- `out_exc`  out  1  misaligned/illegal-length access
- `fwd_idx`, `fwd_val`  out  5, DATA_L  forward source; idx 0 = none
- `ld_busy_idx`  out  5  destination of in-flight load; 0 = none

## Operation
- States: IDLE, REQ (mem_req_valid high), WAIT (awaiting response).
- `in_ready` = state==IDLE and (!out_valid or out_ready).
- Accept in IDLE: latch op, len, addr, wdata, wb_e, wb_idx.
  - Misaligned (addr mod 2^len ≠ 0) or len=3 with DATA_L=32: no request. Output loads next cycle with out_exc=1, out_wb_e=0, out_wb_data=addr; stay IDLE.
  - op none: output loads next cycle with out_wb_data=addr; stay IDLE.
  - store/load: go to REQ.
- REQ: hold all mem_req_* stable until mem_req_ready.
  - Store: on handshake, output loads (posted write, out_wb_data=addr) -> IDLE.
  - Load: on handshake -> WAIT.
- WAIT: on mem_resp_valid, extract lane at addr low bits, then sign-extend (10) or zero-extend (11) to DATA_L. Result goes to out_wb_data; output loads -> IDLE.
- Byte enables: 2^len consecutive ones starting at lane addr[low]. Store data shifted left by 8·addr[low].
- out_valid cleared on out_ready when no new load into the output register in the same cycle; new load takes priority.
- fwd_idx = out_wb_idx when out_valid && out_wb_e, else 0. fwd_val = out_wb_data.
- ld_busy_idx = latched wb_idx in REQ/WAIT for loads with wb_e, else 0.
- mem_resp_valid outside WAIT: ignored.

## Timing
- Reset: all outputs 0, state IDLE, in_ready 1 after reset release. Any in-flight request is abandoned and late responses are ignored.
- none/exception: accept at cycle N, out_valid at N+1.
- Store: mem_req_valid from N+1. Handshake at cycle M, out_valid at M+1.
- Load: response earliest M+1. Response at cycle R gives out_valid at R+1.
- Back-to-back none ops with out_ready=1: one per cycle.
- out_ready=0 with out_valid=1: in_ready=0, so no new accept.

## Structure
- Shared package `ma_pkg`:
  - op codes `MA_OP_NONE/ST/LDS/LDU`
  - length codes `MA_LEN_B/H/W/D`
  - state encoding
  - `fwd_idx` width constant
- Sub-module `mem_align` (combinational, parametrised on DATA_L): store shift and byte-enable generation, load extract and extend.

## Test plan
- DATA_L=32, op none, addr 0x1234, wb_idx 5 -> out_valid next cycle, out_wb_data 0x1234, fwd_idx 5.
- Load signed byte, addr 0x103, rdata 0x80AABBCC -> req addr 0x100, be 0b1000, out_wb_data 0xFFFFFF80.
- Load unsigned half, addr 0x102, rdata 0x80AABBCC -> out_wb_data 0x000080AA. ld_busy_idx = wb_idx until response.
- Store half 0xBEEF at addr 0x202, mem_req_ready held low 3 cycles -> req stable, be 0b1100, wdata 0xBEEF0000, out_valid the cycle after ready.
- Load word at addr 0x101 -> no request, out_exc=1, out_wb_e=0.
- Reset asserted in WAIT, then stray mem_resp_valid -> all outputs 0, response ignored, next op accepted normally.
